// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Computes a - b - bin over WIDTH clocks and publishes diff/bout/ovf on completion.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic           brw_r;
  logic [CW-1:0]  cnt_r;
  logic           accept_s;
  logic           last_bit_s;
  logic           d_bit_s;
  logic           brw_nx_s;

  assign accept_s   = start && (state_r != SHIFT);
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
  assign d_bit_s    = a_r[0] ^ b_r[0] ^ brw_r;
  assign brw_nx_s   = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & brw_r);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = SHIFT;
        else       state_nx_s = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) state_nx_s = DONE;
        else            state_nx_s = SHIFT;
      end
      DONE: begin
        if (start) state_nx_s = SHIFT;
        else       state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: the minuend register doubles as the result shift register,
  // taking each difference bit in at the top as its operand bit leaves the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      brw_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= {WIDTH{1'b0}};
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= (state_nx_s == SHIFT);
      done <= (state_nx_s == DONE);
      if (accept_s) begin
        a_r   <= a;
        b_r   <= b;
        brw_r <= bin;
        cnt_r <= {CW{1'b0}};
      end else if (state_r == SHIFT) begin
        a_r   <= {d_bit_s, a_r[WIDTH-1:1]};
        b_r   <= {1'b0, b_r[WIDTH-1:1]};
        brw_r <= brw_nx_s;
        cnt_r <= cnt_r + CW'(1);
        // brw_r is the borrow into the MSB here, brw_nx_s the borrow out of it
        if (last_bit_s) begin
          diff <= {d_bit_s, a_r[WIDTH-1:1]};
          bout <= brw_nx_s;
          ovf  <= brw_r ^ brw_nx_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 and WIDTH=2 instances checked
// against an arithmetic reference model of a - b - bin.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start2, bin2, busy2, done2, bout2, ovf2;
  logic [1:0] a2, b2, diff2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for bout, signed range test for ovf
  function automatic void model(input int w, input int av, input int bv, input int bi,
                                output logic [31:0] d, output logic bo, output logic ov);
    int full, sa, sb, half, sres;
    half = 1 << (w - 1);
    full = av - bv - bi;
    d    = 32'(full) & ((32'd1 << w) - 32'd1);
    bo   = (full < 0);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    sres = sa - sb - bi;
    ov   = (sres < -half) || (sres >= half);
  endfunction

  function automatic logic [31:0] obs_diff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff2);
  endfunction
  function automatic logic [31:0] obs_bout(input int w);
    return (w == 8) ? 32'(bout8) : 32'(bout2);
  endfunction
  function automatic logic [31:0] obs_ovf(input int w);
    return (w == 8) ? 32'(ovf8) : 32'(ovf2);
  endfunction
  function automatic logic [31:0] obs_done(input int w);
    return (w == 8) ? 32'(done8) : 32'(done2);
  endfunction
  function automatic logic [31:0] obs_busy(input int w);
    return (w == 8) ? 32'(busy8) : 32'(busy2);
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi);
    if (w == 8) begin
      start8 = s; a8 = av; b8 = bv; bin8 = bi;
    end else begin
      start2 = s; a2 = av[1:0]; b2 = bv[1:0]; bin2 = bi;
    end
  endtask

  task automatic expect_result(input int w, input int av, input int bv, input int bi,
                               input string tag);
    logic [31:0] ed;
    logic        eb, eo;
    model(w, av, bv, bi, ed, eb, eo);
    check({tag, ".diff"}, obs_diff(w), ed);
    check({tag, ".bout"}, obs_bout(w), 32'(eb));
    check({tag, ".ovf"},  obs_ovf(w),  32'(eo));
  endtask

  // One operation; optionally pulses start with other operands mid-SHIFT
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input string tag, input bit mid_start);
    int seen, at;
    seen = 0;
    at   = -1;
    @(negedge clk);
    drive(w, 1'b1, av, bv, bi);
    for (int n = 0; n < w + 6; n++) begin
      @(negedge clk);
      if (n == 0) check({tag, ".busy"}, obs_busy(w), 32'd1);
      if (obs_done(w) == 32'd1) begin
        seen++;
        if (at < 0) at = n;
      end
      if (mid_start && n == 3) drive(w, 1'b1, ~av, bv + 8'd1, ~bi);
      else                     drive(w, 1'b0, av, bv, bi);
    end
    check({tag, ".pulses"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(at), 32'(w));
    expect_result(w, int'(av), int'(bv), int'(bi), tag);
  endtask

  initial begin
    int          dones;
    logic [7:0]  ca, cb;
    logic        cbi;

    rst = 1'b1;
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", obs_busy(8), 32'd0);
    check("rst.done", obs_done(8), 32'd0);
    check("rst.diff", obs_diff(8), 32'd0);
    check("rst.bout", obs_bout(8), 32'd0);
    check("rst.ovf",  obs_ovf(8),  32'd0);
    check("rst.diff2", obs_diff(2), 32'd0);

    run_op(8, 8'h05, 8'h03, 1'b0, "v1", 1'b0);
    run_op(8, 8'h00, 8'h01, 1'b0, "v2", 1'b0);
    run_op(8, 8'h00, 8'h00, 1'b1, "v3", 1'b0);
    run_op(8, 8'h80, 8'h01, 1'b0, "v4", 1'b0);
    run_op(8, 8'h7F, 8'hFF, 1'b0, "v5", 1'b0);
    run_op(8, 8'h5A, 8'h5A, 1'b0, "eq", 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), 1'b0);
    end

    run_op(8, 8'h3C, 8'h71, 1'b1, "mid", 1'b1);

    // Reset just before bit 4 is processed
    @(negedge clk);
    drive(8, 1'b1, 8'h99, 8'h12, 1'b0);
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      drive(8, 1'b0, 8'h99, 8'h12, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", obs_busy(8), 32'd0);
    check("rstmid.done", obs_done(8), 32'd0);
    check("rstmid.diff", obs_diff(8), 32'd0);
    check("rstmid.bout", obs_bout(8), 32'd0);
    check("rstmid.ovf",  obs_ovf(8),  32'd0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    check("rstmid.nodone", 32'(dones), 32'd0);
    run_op(8, 8'h10, 8'h20, 1'b1, "after_rst", 1'b0);

    // rst wins over start at the same edge
    @(negedge clk);
    rst = 1'b1;
    drive(8, 1'b1, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(8, 1'b0, 8'h01, 8'h01, 1'b0);
    check("rstprio.busy", obs_busy(8), 32'd0);
    @(negedge clk);
    check("rstprio.busy2", obs_busy(8), 32'd0);

    // Back-to-back with start held high; junk operands while busy must be ignored
    ca  = 8'($urandom_range(0, 255));
    cb  = 8'($urandom_range(0, 255));
    cbi = 1'($urandom_range(0, 1));
    drive(8, 1'b1, ca, cb, cbi);
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      check("b2b.done", obs_done(8), 32'((n % 9) == 8));
      if (done8 === 1'b1) begin
        expect_result(8, int'(ca), int'(cb), int'(cbi), "b2b");
        ca  = 8'($urandom_range(0, 255));
        cb  = 8'($urandom_range(0, 255));
        cbi = 1'($urandom_range(0, 1));
        drive(8, 1'b1, ca, cb, cbi);
      end else begin
        drive(8, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end
    end
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (12) @(negedge clk);

    // WIDTH=2 exhaustive sweep
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          run_op(2, 8'(av), 8'(bv), 1'(bi), $sformatf("w2_%0d_%0d_%0d", av, bv, bi), 1'b0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
